// File: rtl/idex_pkg.sv
// Shared constants for the ID/EX pipeline register: default widths, control-bundle
// bit positions and the ALUOp encoding produced by the main decoder.
package idex_pkg;

    localparam int CTRL_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int CNT_W_DEF  = 16;

    // Control bundle layout, MSB first: RegDst .. Branch, then ALUOp[2:0].
    localparam int CTRL_REG_DST   = 9;
    localparam int CTRL_ALU_SRC   = 8;
    localparam int CTRL_MEM2REG   = 7;
    localparam int CTRL_REG_WRITE = 6;
    localparam int CTRL_MEM_READ  = 5;
    localparam int CTRL_MEM_WRITE = 4;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_ALUOP_MSB = 2;
    localparam int CTRL_ALUOP_LSB = 0;
    localparam int ALUOP_W        = 3;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD   = 3'd0,
        ALUOP_SUB   = 3'd1,
        ALUOP_RTYPE = 3'd2,
        ALUOP_AND   = 3'd3,
        ALUOP_OR    = 3'd4,
        ALUOP_SLT   = 3'd5,
        ALUOP_LUI   = 3'd6,
        ALUOP_XOR   = 3'd7
    } alu_op_e;

    // Width of the packed stored entry: control, four data words, three specifiers.
    function automatic int payload_width(input int ctrl_w, input int data_w, input int reg_w);
        return ctrl_w + 4 * data_w + 3 * reg_w;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: "main" drives the outputs, "skid" catches the one entry
// that arrives while main is stalled. in_ready comes straight from a flop.
module skid_buffer
    import idex_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Handshake: a beat transfers on a rising edge where valid and ready are both
    // high; valid must not depend on ready, and flush overrides any transfer.
    logic         main_valid_q, main_valid_d;
    logic [W-1:0] main_data_q,  main_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         in_ready_q,   in_ready_d;
    logic         in_fire;
    logic         out_fire;

    assign in_fire  = in_valid & in_ready_q & ~flush;
    assign out_fire = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_fire) begin
            // Skid is older than any new input, so it takes priority for main.
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (main_valid_q) begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end else begin
                main_data_d  = in_data;
                main_valid_d = 1'b1;
            end
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/pipe_stage_idex.sv
// ID/EX pipeline register: packs the decoded instruction into one vector, buffers
// it in a skid buffer, forces a zero control bundle on bubbles and counts bubbles.
module pipe_stage_idex
    import idex_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int               PAY_W   = payload_width(CTRL_W, DATA_W, REG_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAY_W-1:0]  pay_in;
    logic [PAY_W-1:0]  pay_out;
    logic [CTRL_W-1:0] ctrl_held;
    logic              main_valid;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    assign pay_in = {ctrl_in, pc_in, rd1_in, rd2_in, imm_in, rs_in, rt_in, rd_in};

    skid_buffer #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (main_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    assign {ctrl_held, pc_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out} = pay_out;

    // Data fields keep their last value on a bubble; only control is squashed so
    // EX sees no register or memory writes.
    assign out_valid = main_valid;
    assign ctrl_out  = main_valid ? ctrl_held : '0;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!main_valid && out_ready && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_idex.sv
// Bench for pipe_stage_idex: directed scenarios plus random traffic, all checked
// against a two-deep FIFO model of the stage.
module tb_pipe_stage_idex;

    localparam int CW      = 10;
    localparam int DW      = 32;
    localparam int RW      = 5;
    localparam int CNT_W   = 4;
    localparam int PW      = CW + 4 * DW + 3 * RW;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    logic flush;
    logic in_valid;
    logic out_ready;
    logic [PW-1:0] in_pay;

    logic          in_ready;
    logic          out_valid;
    logic [CW-1:0] ctrl_out;
    logic [DW-1:0] pc_out, rd1_out, rd2_out, imm_out;
    logic [RW-1:0] rs_out, rt_out, rd_out;
    logic [CNT_W-1:0] bubble_cnt;
    logic [PW-CW-1:0] data_out;

    assign data_out = {pc_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out};

    pipe_stage_idex #(
        .CTRL_W (CW),
        .DATA_W (DW),
        .REG_W  (RW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ctrl_in    (in_pay[PW-1 -: CW]),
        .pc_in      (in_pay[PW-CW-1 -: DW]),
        .rd1_in     (in_pay[PW-CW-DW-1 -: DW]),
        .rd2_in     (in_pay[PW-CW-2*DW-1 -: DW]),
        .imm_in     (in_pay[PW-CW-3*DW-1 -: DW]),
        .rs_in      (in_pay[3*RW-1 -: RW]),
        .rt_in      (in_pay[2*RW-1 -: RW]),
        .rd_in      (in_pay[RW-1:0]),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ctrl_out   (ctrl_out),
        .pc_out     (pc_out),
        .rd1_out    (rd1_out),
        .rd2_out    (rd2_out),
        .imm_out    (imm_out),
        .rs_out     (rs_out),
        .rt_out     (rt_out),
        .rd_out     (rd_out),
        .bubble_cnt (bubble_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: accepted entries in arrival order, capacity two.
    logic [PW-1:0]    q[$];
    logic [PW-1:0]    last_pay;
    int               m_cnt;
    logic             exp_valid;
    logic             exp_ready;
    logic [CW-1:0]    exp_ctrl;
    logic [PW-CW-1:0] exp_data;
    logic [CNT_W-1:0] exp_cnt;

    int n_checks;
    int n_fail;

    function automatic logic [PW-1:0] rand_pay();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] make_pay(input logic [CW-1:0] ctrl, input logic [DW-1:0] pc);
        logic [PW-1:0] p;
        p = rand_pay();
        p[PW-1 -: CW]    = ctrl;
        p[PW-CW-1 -: DW] = pc;
        return p;
    endfunction

    task automatic model_outputs();
        exp_valid = (q.size() > 0);
        exp_ready = (q.size() < 2);
        exp_ctrl  = exp_valid ? q[0][PW-1 -: CW] : '0;
        exp_data  = last_pay[PW-CW-1:0];
        exp_cnt   = m_cnt[CNT_W-1:0];
    endtask

    task automatic model_reset();
        q.delete();
        last_pay = '0;
        m_cnt    = 0;
        model_outputs();
    endtask

    // Driver: one clock edge, model updated with the inputs the DUT saw.
    task automatic step();
        int n;
        bit acc;
        bit pop;
        @(posedge clk);
        n   = q.size();
        acc = in_valid && (n < 2) && !flush;
        pop = (n > 0) && out_ready;
        if (n == 0 && out_ready && m_cnt < CNT_MAX) m_cnt++;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(in_pay);
        end
        if (q.size() > 0) last_pay = q[0];
        #1;
        model_outputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pay = rand_pay();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_checks++; if (ctrl_out !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", ctrl_out); end
        n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_out); end
        n_checks++; if (bubble_cnt !== '0) begin n_fail++; $display("FAIL reset_bubble: got %0d want 0", bubble_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [DW-1:0] exp_pc;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc   = 32'(i * 4);
            in_pay   = make_pay(CW'($urandom()), exp_pc);
            in_valid = 1'b1;
            step();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, out_valid); end
            n_checks++; if (pc_out !== exp_pc) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pc_out, exp_pc); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %0b want 1", i, in_ready); end
            n_checks++; if (ctrl_out !== exp_ctrl) begin n_fail++; $display("FAIL stream_ctrl[%0d]: got %h want %h", i, ctrl_out, exp_ctrl); end
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid: got %0b want 0", out_valid); end
        n_checks++; if (ctrl_out !== '0) begin n_fail++; $display("FAIL stream_bubble_ctrl: got %h want 0", ctrl_out); end
        n_checks++; if (pc_out !== 32'hC) begin n_fail++; $display("FAIL stream_hold_pc: got %h want c", pc_out); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pay    = make_pay(CW'($urandom()), 32'h10);
        step();
        n_checks++; if (pc_out !== 32'h10) begin n_fail++; $display("FAIL skid_first_pc: got %h want 10", pc_out); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_first_ready: got %0b want 1", in_ready); end
        in_pay = make_pay(CW'($urandom()), 32'h14);
        step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_full_ready: got %0b want 0", in_ready); end
        n_checks++; if (pc_out !== 32'h10) begin n_fail++; $display("FAIL skid_stall_pc: got %h want 10", pc_out); end
        n_checks++; if (ctrl_out !== exp_ctrl) begin n_fail++; $display("FAIL skid_stall_ctrl: got %h want %h", ctrl_out, exp_ctrl); end
        in_pay = make_pay(CW'($urandom()), 32'h99);
        step();
        n_checks++; if (pc_out !== 32'h10 || in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_hold: got pc %h rdy %0b want pc 10 rdy 0", pc_out, in_ready); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_checks++; if (pc_out !== 32'h14 || out_valid !== 1'b1) begin n_fail++; $display("FAIL skid_second_pc: got %h v%0b want 14 v1", pc_out, out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_back: got %0b want 1", in_ready); end
        n_checks++; if (data_out !== exp_data) begin n_fail++; $display("FAIL skid_second_data: got %h want %h", data_out, exp_data); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_empty: got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pay    = make_pay(10'h3FF, 32'h18);
        step();
        in_pay    = make_pay(CW'($urandom()), 32'h1C);
        step();
        n_checks++; if (ctrl_out !== 10'h3FF) begin n_fail++; $display("FAIL flush_pre_ctrl: got %h want 3ff", ctrl_out); end
        flush  = 1'b1;
        in_pay = make_pay(10'h3FF, 32'h20);
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
        n_checks++; if (ctrl_out !== '0) begin n_fail++; $display("FAIL flush_ctrl: got %h want 0", ctrl_out); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b want 1", in_ready); end
        n_checks++; if (pc_out !== 32'h18) begin n_fail++; $display("FAIL flush_hold_pc: got %h want 18", pc_out); end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (out_valid !== 1'b0 || pc_out === 32'h20) begin n_fail++; $display("FAIL flush_after[%0d]: got v%0b pc %h want v0 pc!=20", i, out_valid, pc_out); end
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pay   = make_pay(CW'($urandom()), 32'h24);
        step();
        n_checks++; if (out_valid !== 1'b0 || data_out !== exp_data) begin n_fail++; $display("FAIL flush_empty: got v%0b data %h want v0 data %h", out_valid, data_out, exp_data); end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pay    = make_pay(CW'($urandom()), 32'h30);
        step();
        in_pay    = make_pay(CW'($urandom()), 32'h34);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (out_valid !== 1'b0 || ctrl_out !== '0) begin n_fail++; $display("FAIL rstmid_valid_ctrl: got v%0b c%h want 0", out_valid, ctrl_out); end
        n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", data_out); end
        n_checks++; if (bubble_cnt !== '0) begin n_fail++; $display("FAIL rstmid_bubble: got %0d want 0", bubble_cnt); end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %0b want 1", in_ready); end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_pay    = make_pay(CW'($urandom()), 32'h40);
        step();
        n_checks++; if (out_valid !== 1'b1 || pc_out !== 32'h40) begin n_fail++; $display("FAIL rstmid_first: got v%0b pc %h want v1 pc 40", out_valid, pc_out); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_bubble();
        int want;
        #2;
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            want = (i < CNT_MAX) ? i : CNT_MAX;
            n_checks++; if (bubble_cnt !== CNT_W'(want)) begin n_fail++; $display("FAIL bubble_cnt[%0d]: got %0d want %0d", i, bubble_cnt, want); end
        end
        out_ready = 1'b0;
        step();
        n_checks++; if (bubble_cnt !== CNT_W'(CNT_MAX)) begin n_fail++; $display("FAIL bubble_hold: got %0d want %0d", bubble_cnt, CNT_MAX); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_pay    = rand_pay();
            step();
            n_checks++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, out_valid, exp_valid); end
            n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, in_ready, exp_ready); end
            n_checks++; if (ctrl_out !== exp_ctrl) begin n_fail++; $display("FAIL rnd_ctrl[%0d]: got %h want %h", i, ctrl_out, exp_ctrl); end
            n_checks++; if (data_out !== exp_data) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", i, data_out, exp_data); end
            n_checks++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL rnd_bubble[%0d]: got %0d want %0d", i, bubble_cnt, exp_cnt); end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_reset_mid();
        test_bubble();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_idex.md
PIPE_STAGE_IDEX -- requirements
Module: pipe_stage_idex

Interface
REQ-001 Parameter CTRL_W, default 10, control bundle width: RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[2:0].
REQ-002 Parameter DATA_W, default 32, width of PC, ReadData1, ReadData2, SignExtend.
REQ-003 Parameter REG_W, default 5, width of rs, rt, rd.
REQ-004 Parameter CNT_W, default 16, bubble counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 flush  in  1  squash all held and incoming entries (branch taken).
REQ-008 in_valid  in  1  ID stage presents an entry.
REQ-009 in_ready  out  1  stage can accept; driven from a register only.
REQ-010 ctrl_in  in  CTRL_W  control bundle.
REQ-011 pc_in, rd1_in, rd2_in, imm_in  in  DATA_W each  PC, ReadData1, ReadData2, SignExtend.
REQ-012 rs_in, rt_in, rd_in  in  REG_W each  register specifiers.
REQ-013 out_valid  out  1  EX-side entry valid.
REQ-014 out_ready  in  1  EX stage accepts; low = stall.
REQ-015 ctrl_out, pc_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out  out  widths as inputs  registered payload.
REQ-016 bubble_cnt  out  CNT_W  saturating count of bubble cycles.

Function
REQ-017 Stage SHALL hold two entries: main (drives outputs) and skid.
REQ-018 in_ready SHALL equal NOT skid_valid, registered.
REQ-019 Input transfer SHALL occur when in_valid & in_ready; output transfer when out_valid & out_ready.
REQ-020 Input transfer with main empty, or main draining this cycle with skid empty, SHALL load main; latency in->out 1 cycle.
REQ-021 Input transfer while main holds and does not drain SHALL load skid; in_ready SHALL go low the next cycle.
REQ-022 Output transfer with skid valid SHALL move skid to main and clear skid_valid; in_ready high next cycle.
REQ-023 Entries SHALL leave in arrival order; no entry dropped or duplicated absent flush.
REQ-024 While out_valid=0, ctrl_out SHALL be all-zero (bubble); data/specifier outputs hold last value.
REQ-025 Stall (out_ready=0) SHALL hold every output stable.
REQ-026 flush=1 SHALL clear main and skid valid bits and zero ctrl_out next cycle; the same-cycle input is discarded, flush beats accept.
REQ-027 flush with stage empty SHALL be a no-op apart from discarding input.
REQ-028 bubble_cnt SHALL increment when out_valid=0 & out_ready=1 and saturate at 2^CNT_W-1, no wrap.
REQ-029 Payload is packed as one vector of CTRL_W+4*DATA_W+3*REG_W bits for storage.

Reset
REQ-030 rst_n low SHALL asynchronously clear main/skid valid, ctrl_out, all data outputs and bubble_cnt to 0 and set in_ready to 1 after release.
REQ-031 Reset mid-transfer SHALL discard all held entries; the first accept follows the first rising edge with rst_n high.

Structure
REQ-032 Package idex_pkg SHALL hold CTRL_W/DATA_W/REG_W defaults, control-bit index constants and the ALUOp encoding.
REQ-033 One sub-module skid_buffer (width-parametrised, valid/ready, flush) SHALL implement REQ-017..REQ-023 and REQ-026; pipe_stage_idex wraps it with packing, bubble gating and counter.

Verification
REQ-034 Stream 4 entries, pc_in=0x0,0x4,0x8,0xC, out_ready=1 -> pc_out same order, one cycle later each, in_ready stays 1.
REQ-035 Accept pc=0x10, out_ready=0 two cycles, offer pc=0x14 -> skid fills, in_ready=0; out_ready=1 -> 0x10 then 0x14, in_ready back to 1.
REQ-036 Two entries held, flush=1 with in_valid=1 pc=0x20 -> next cycle out_valid=0, ctrl_out=0, 0x20 never appears.
REQ-037 rst_n low while skid full -> outputs 0 immediately; after release in_valid pc=0x40 -> pc_out=0x40 next cycle.
REQ-038 CNT_W=4, in_valid=0, out_ready=1 for 20 cycles -> bubble_cnt reaches 15 and holds.
REQ-039 ctrl_in=0x3FF, out_ready=0, flush -> ctrl_out=0 next cycle, out_valid=0.
